register_file: RTL and testbench
================================

# register_file

Architectural register file with rename tags for the out-of-order core. It consumes the reorder buffer's commit stream (dest, value, ROB id) and records which ROB entry will produce each register, as allocated by the instruction unit at issue. For every issuing instruction it resolves rs1/rs2 to a ready value or a pending ROB tag. To do this it drives the ROB's dependency query ports and forwards any value the ROB already holds. It sits between the instruction unit, the reorder buffer and the reservation stations.

## Interface
- ROB_WIDTH, 4, ROB index width; must match the reorder buffer.
- clockIn  in  1  clock; all state updates on rising edge.
- resetIn  in  1  asynchronous, active-high reset.
- readyIn  in  1  global enable; when low, no state changes.
- clear  in  1  misprediction flush from the ROB.
- regUpdateValid  in  1  ROB commit valid.
- regUpdateDest  in  5  committed destination register.
- regValue  in  32  committed value.
- regUpdateRobId  in  ROB_WIDTH  ROB entry being committed.
- renameValid  in  1  instruction unit issues an instruction with a destination.
- renameDest  in  5  issued rd.
- renameRobId  in  ROB_WIDTH  ROB entry allocated to that rd.
- rs1  in  5  source register 1 of the issuing instruction.
- rs2  in  5  source register 2 of the issuing instruction.
- rs1Dep  out  ROB_WIDTH  tag of rs1's producer, driven to the ROB query port.
- rs1RobReady  in  1  ROB reports the rs1Dep entry valid and ready.
- rs1RobValue  in  32  ROB value for rs1Dep.
- rs2Dep, rs2RobReady, rs2RobValue: same as the rs1 set, for rs2.
- rs1Ready  out  1  rs1 operand value is available.
- rs1Value  out  32  rs1 operand value; meaningful only when rs1Ready is high.
- rs1Tag  out  ROB_WIDTH  producer tag; meaningful only when rs1Ready is low.
- rs2Ready, rs2Value, rs2Tag: same as the rs1 set, for rs2.

## Operation
- State per register i (0..31): value[i] (32 b), busy[i], tag[i] (ROB_WIDTH).
- **Commit.** When regUpdateValid and dest≠0:
  - value[dest] ← regValue.
  - If busy[dest] and tag[dest]==regUpdateRobId, then busy[dest] ← 0.
  - On a tag mismatch (a younger rename exists), busy and tag are untouched.
- **Rename.** When renameValid, dest≠0 and !clear: busy[dest] ← 1 and tag[dest] ← renameRobId.
- **Commit and rename to the same register in one cycle.** Rename wins on busy/tag. The value is still written.
- **Clear.** All busy bits are cleared. Values are kept. Rename in the same cycle is dropped. A commit in the same cycle is still applied.
- **x0.** Always reads value 0 and ready 1. It is never renamed or written.
- **Operand resolution** (combinational, per source s), in priority order:
  1. s==0 → ready, value 0.
  2. !busy[s] → ready, value[s].
  3. regUpdateValid && regUpdateDest==s && regUpdateRobId==tag[s] → ready, regValue (same-cycle commit bypass).
  4. rsXRobReady → ready, rsXRobValue (ROB forwarding).
  5. Otherwise → not ready, rsXTag = tag[s].
- rsXDep = tag[rsX] at all times, including when the register is not busy. That is harmless.
- Same-cycle rename of a register being looked up is not visible to the lookup. The lookup returns pre-rename state, so an instruction with rd==rs reads its old producer.

## Timing
- Reset (asynchronous): all value = 0 and all busy = 0; tags = 0.
- Outputs are combinational from state, so right after reset every rsXReady = 1, rsXValue = 0 and rsXDep = 0.
- Lookup latency is 0 cycles, combinational from rs1/rs2 and the ROB replies.
- Rename and commit take effect at the next rising edge when readyIn is high.
- readyIn low: state frozen. Lookups still resolve combinationally.
- An asserted reset mid-operation discards all pending renames immediately.
- The ROB drives clear for exactly one cycle after a mispredicted branch retires. Committed values from before the flush persist.

## Structure
- Shared package holds REG_COUNT=32, REG_ADDR_WIDTH=5, ZERO_REG=5'd0, and ROB_WIDTH as the single source shared with reorder_buffer.
- One sub-module, reg_operand_lookup, implements the priority resolution for one source. It is instantiated twice, for rs1 and rs2.
- State arrays live in register_file itself.

## Test plan
- **Reset then lookup.** Reset, rs1=5 → rs1Ready=1, rs1Value=0, rs1Dep=0.
- **Rename then commit.** Rename x3→tag 2, then rs1=3 with rs1RobReady=0 → rs1Ready=0, rs1Tag=2. Commit dest=3, id=2, value 0xDEADBEEF → next cycle rs1Ready=1, rs1Value=0xDEADBEEF.
- **Stale commit.**
  - Rename x4→tag 1, then rename x4→tag 6.
  - Commit dest=4, id=1, value 7 → value[4]=7, but rs1 on x4 stays not ready with tag 6.
  - Commit id=6 → ready.
- **Forwarding and bypass.**
  - x7 busy tag 3; rs2RobReady=1, rs2RobValue=0x55 → rs2Ready=1, rs2Value=0x55.
  - Same-cycle commit id=3, value 0x66, ROB not ready → rs2Value=0x66.
- **Clear and x0.**
  - Rename x8→tag 5 and x9→tag 6.
  - Assert clear together with renameValid for x10 → next cycle x8, x9 and x10 are all ready, holding their old values.
  - Rename x0 → x0 stays ready with value 0.
- **Collision and readyIn.**
  - Commit x11 id=2 while renaming x11→tag 9 in the same cycle → value updated, busy=1, tag=9.
  - Repeat with readyIn=0 → no change.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared constants and types for the architectural register file and its rename tags.
// ROB_WIDTH here must match the reorder buffer's index width.
package register_file_pkg;
    localparam int REG_COUNT      = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int ROB_WIDTH      = 4;
    localparam int DATA_WIDTH     = 32;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [ROB_WIDTH-1:0]      rob_id_t;
    typedef logic [DATA_WIDTH-1:0]     word_t;

    localparam reg_addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/register_file_operand_lookup.sv
// Resolves one source operand to a ready value or a pending producer tag.
// Priority: x0, idle register, same-cycle commit bypass, ROB forwarding, else wait on tag.
module reg_operand_lookup
    import register_file_pkg::*;
(
    input  reg_addr_t src,
    input  logic      src_busy,
    input  rob_id_t   src_tag,
    input  word_t     src_value,
    input  logic      commit_valid,
    input  reg_addr_t commit_dest,
    input  rob_id_t   commit_id,
    input  word_t     commit_value,
    input  logic      rob_ready,
    input  word_t     rob_value,
    output logic      ready,
    output word_t     value,
    output rob_id_t   tag
);
    always_comb begin
        ready = 1'b0;
        value = '0;
        tag   = src_tag;
        if (src == ZERO_REG) begin
            ready = 1'b1;
        end else if (!src_busy) begin
            ready = 1'b1;
            value = src_value;
        end else if (commit_valid && commit_dest == src && commit_id == src_tag) begin
            ready = 1'b1;
            value = commit_value;
        end else if (rob_ready) begin
            ready = 1'b1;
            value = rob_value;
        end
    end
endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags, ROB commit and flush handling,
// and two combinational operand lookups for the issuing instruction.
module register_file
    import register_file_pkg::*;
(
    input  logic      clockIn,
    input  logic      resetIn,
    input  logic      readyIn,
    input  logic      clear,
    input  logic      regUpdateValid,
    input  reg_addr_t regUpdateDest,
    input  word_t     regValue,
    input  rob_id_t   regUpdateRobId,
    input  logic      renameValid,
    input  reg_addr_t renameDest,
    input  rob_id_t   renameRobId,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    output rob_id_t   rs1Dep,
    input  logic      rs1RobReady,
    input  word_t     rs1RobValue,
    output rob_id_t   rs2Dep,
    input  logic      rs2RobReady,
    input  word_t     rs2RobValue,
    output logic      rs1Ready,
    output word_t     rs1Value,
    output rob_id_t   rs1Tag,
    output logic      rs2Ready,
    output word_t     rs2Value,
    output rob_id_t   rs2Tag
);
    word_t                value_reg [REG_COUNT];
    rob_id_t              tag_reg   [REG_COUNT];
    logic [REG_COUNT-1:0] busy_reg;

    logic commit_en;
    logic rename_en;

    assign commit_en = regUpdateValid && (regUpdateDest != ZERO_REG);
    assign rename_en = renameValid && (renameDest != ZERO_REG) && !clear;

    // Rename is applied after commit so it wins busy/tag on a same-register collision;
    // clear is applied last so it overrides any busy bit set this cycle.
    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            busy_reg <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                value_reg[i] <= '0;
                tag_reg[i]   <= '0;
            end
        end else if (readyIn) begin
            if (commit_en) begin
                value_reg[regUpdateDest] <= regValue;
                if (busy_reg[regUpdateDest] && tag_reg[regUpdateDest] == regUpdateRobId)
                    busy_reg[regUpdateDest] <= 1'b0;
            end
            if (rename_en) begin
                busy_reg[renameDest] <= 1'b1;
                tag_reg[renameDest]  <= renameRobId;
            end
            if (clear)
                busy_reg <= '0;
        end
    end

    assign rs1Dep = tag_reg[rs1];
    assign rs2Dep = tag_reg[rs2];

    reg_operand_lookup u_rs1_lookup (
        .src          (rs1),
        .src_busy     (busy_reg[rs1]),
        .src_tag      (tag_reg[rs1]),
        .src_value    (value_reg[rs1]),
        .commit_valid (regUpdateValid),
        .commit_dest  (regUpdateDest),
        .commit_id    (regUpdateRobId),
        .commit_value (regValue),
        .rob_ready    (rs1RobReady),
        .rob_value    (rs1RobValue),
        .ready        (rs1Ready),
        .value        (rs1Value),
        .tag          (rs1Tag)
    );

    reg_operand_lookup u_rs2_lookup (
        .src          (rs2),
        .src_busy     (busy_reg[rs2]),
        .src_tag      (tag_reg[rs2]),
        .src_value    (value_reg[rs2]),
        .commit_valid (regUpdateValid),
        .commit_dest  (regUpdateDest),
        .commit_id    (regUpdateRobId),
        .commit_value (regValue),
        .rob_ready    (rs2RobReady),
        .rob_value    (rs2RobValue),
        .ready        (rs2Ready),
        .value        (rs2Value),
        .tag          (rs2Tag)
    );
endmodule

// File: tb/tb_register_file.sv
// Directed walk through the rename/commit/clear scenarios, then randomized traffic
// checked against an array-based model of the register file.
module tb_register_file;
    logic        clockIn = 1'b0;
    logic        resetIn;
    logic        readyIn;
    logic        clear;
    logic        regUpdateValid;
    logic [4:0]  regUpdateDest;
    logic [31:0] regValue;
    logic [3:0]  regUpdateRobId;
    logic        renameValid;
    logic [4:0]  renameDest;
    logic [3:0]  renameRobId;
    logic [4:0]  rs1, rs2;
    logic [3:0]  rs1Dep, rs2Dep;
    logic        rs1RobReady, rs2RobReady;
    logic [31:0] rs1RobValue, rs2RobValue;
    logic        rs1Ready, rs2Ready;
    logic [31:0] rs1Value, rs2Value;
    logic [3:0]  rs1Tag, rs2Tag;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_val  [32];
    logic [3:0]  m_tag  [32];
    logic        m_busy [32];

    register_file dut (
        .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn), .clear(clear),
        .regUpdateValid(regUpdateValid), .regUpdateDest(regUpdateDest),
        .regValue(regValue), .regUpdateRobId(regUpdateRobId),
        .renameValid(renameValid), .renameDest(renameDest), .renameRobId(renameRobId),
        .rs1(rs1), .rs2(rs2),
        .rs1Dep(rs1Dep), .rs1RobReady(rs1RobReady), .rs1RobValue(rs1RobValue),
        .rs2Dep(rs2Dep), .rs2RobReady(rs2RobReady), .rs2RobValue(rs2RobValue),
        .rs1Ready(rs1Ready), .rs1Value(rs1Value), .rs1Tag(rs1Tag),
        .rs2Ready(rs2Ready), .rs2Value(rs2Value), .rs2Tag(rs2Tag)
    );

    always #5 clockIn = ~clockIn;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_tag[i] = '0; m_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        readyIn = 1'b1; clear = 1'b0;
        regUpdateValid = 1'b0; regUpdateDest = '0; regValue = '0; regUpdateRobId = '0;
        renameValid = 1'b0; renameDest = '0; renameRobId = '0;
        rs1RobReady = 1'b0; rs1RobValue = '0; rs2RobReady = 1'b0; rs2RobValue = '0;
    endtask

    // Advance one clock and apply the architectural rules to the model.
    task automatic step();
        @(posedge clockIn);
        if (resetIn) begin
            model_reset();
        end else if (readyIn) begin
            if (regUpdateValid && regUpdateDest != 0) begin
                m_val[regUpdateDest] = regValue;
                if (m_busy[regUpdateDest] && m_tag[regUpdateDest] == regUpdateRobId)
                    m_busy[regUpdateDest] = 1'b0;
            end
            if (clear) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (renameValid && renameDest != 0) begin
                m_busy[renameDest] = 1'b1;
                m_tag[renameDest]  = renameRobId;
            end
        end
        #1;
    endtask

    task automatic check_src(input string name, input logic [4:0] s, input logic rob_rdy,
                             input logic [31:0] rob_val, input logic rdy, input logic [31:0] val,
                             input logic [3:0] tg, input logic [3:0] dep);
        logic        e_rdy;
        logic [31:0] e_val;
        e_rdy = 1'b1;
        e_val = '0;
        if (s == 0) begin
            e_val = '0;
        end else if (!m_busy[s]) begin
            e_val = m_val[s];
        end else if (regUpdateValid && regUpdateDest == s && regUpdateRobId == m_tag[s]) begin
            e_val = regValue;
        end else if (rob_rdy) begin
            e_val = rob_val;
        end else begin
            e_rdy = 1'b0;
        end
        chk({name, "_ready"}, 32'(rdy), 32'(e_rdy));
        if (e_rdy) chk({name, "_value"}, val, e_val);
        else       chk({name, "_tag"}, 32'(tg), 32'(m_tag[s]));
        chk({name, "_dep"}, 32'(dep), 32'(m_tag[s]));
    endtask

    initial begin
        model_reset();
        idle();
        rs1 = '0; rs2 = '0;
        resetIn = 1'b1;
        step(); step();
        resetIn = 1'b0;

        // Reset then lookup
        rs1 = 5'd5; #1;
        chk("reset_rdy", 32'(rs1Ready), 32'd1);
        chk("reset_val", rs1Value, 32'd0);
        chk("reset_dep", 32'(rs1Dep), 32'd0);

        // Rename then commit
        renameValid = 1; renameDest = 5'd3; renameRobId = 4'd2; step(); idle();
        rs1 = 5'd3; #1;
        chk("ren_rdy", 32'(rs1Ready), 32'd0);
        chk("ren_tag", 32'(rs1Tag), 32'd2);
        regUpdateValid = 1; regUpdateDest = 5'd3; regUpdateRobId = 4'd2; regValue = 32'hDEADBEEF;
        step(); idle(); #1;
        chk("commit_rdy", 32'(rs1Ready), 32'd1);
        chk("commit_val", rs1Value, 32'hDEADBEEF);

        // Stale commit leaves the younger rename in place
        renameValid = 1; renameDest = 5'd4; renameRobId = 4'd1; step();
        renameRobId = 4'd6; step(); idle();
        regUpdateValid = 1; regUpdateDest = 5'd4; regUpdateRobId = 4'd1; regValue = 32'd7;
        step(); idle();
        rs1 = 5'd4; #1;
        chk("stale_rdy", 32'(rs1Ready), 32'd0);
        chk("stale_tag", 32'(rs1Tag), 32'd6);
        regUpdateValid = 1; regUpdateDest = 5'd4; regUpdateRobId = 4'd6; regValue = 32'h77;
        step(); idle(); #1;
        chk("young_rdy", 32'(rs1Ready), 32'd1);
        chk("young_val", rs1Value, 32'h77);

        // ROB forwarding and same-cycle commit bypass
        renameValid = 1; renameDest = 5'd7; renameRobId = 4'd3; step(); idle();
        rs2 = 5'd7; rs2RobReady = 1; rs2RobValue = 32'h55; #1;
        chk("fwd_rdy", 32'(rs2Ready), 32'd1);
        chk("fwd_val", rs2Value, 32'h55);
        rs2RobReady = 0;
        regUpdateValid = 1; regUpdateDest = 5'd7; regUpdateRobId = 4'd3; regValue = 32'h66; #1;
        chk("byp_rdy", 32'(rs2Ready), 32'd1);
        chk("byp_val", rs2Value, 32'h66);
        step(); idle();

        // Clear drops pending renames and a same-cycle rename; values persist
        renameValid = 1; renameDest = 5'd8; renameRobId = 4'd5; step();
        renameDest = 5'd9; renameRobId = 4'd6; step();
        renameDest = 5'd10; renameRobId = 4'd7; clear = 1; step(); idle();
        rs1 = 5'd8; rs2 = 5'd9; #1;
        chk("clr_x8_rdy", 32'(rs1Ready), 32'd1);
        chk("clr_x8_val", rs1Value, 32'd0);
        chk("clr_x9_rdy", 32'(rs2Ready), 32'd1);
        rs1 = 5'd10; #1;
        chk("clr_x10_rdy", 32'(rs1Ready), 32'd1);
        rs1 = 5'd7; #1;
        chk("clr_x7_val", rs1Value, 32'h66);
        renameValid = 1; renameDest = 5'd0; renameRobId = 4'd3; step(); idle();
        rs1 = 5'd0; #1;
        chk("x0_rdy", 32'(rs1Ready), 32'd1);
        chk("x0_val", rs1Value, 32'd0);
        chk("x0_dep", 32'(rs1Dep), 32'd0);

        // Commit and rename colliding on one register; then the same with readyIn low
        regUpdateValid = 1; regUpdateDest = 5'd11; regUpdateRobId = 4'd2; regValue = 32'h1234;
        renameValid = 1; renameDest = 5'd11; renameRobId = 4'd9; step(); idle();
        rs1 = 5'd11; #1;
        chk("coll_rdy", 32'(rs1Ready), 32'd0);
        chk("coll_tag", 32'(rs1Tag), 32'd9);
        readyIn = 0;
        regUpdateValid = 1; regUpdateDest = 5'd11; regUpdateRobId = 4'd9; regValue = 32'hBAD;
        renameValid = 1; renameDest = 5'd11; renameRobId = 4'd12; step(); idle(); #1;
        chk("frz_rdy", 32'(rs1Ready), 32'd0);
        chk("frz_tag", 32'(rs1Tag), 32'd9);
        clear = 1; step(); idle(); #1;
        chk("coll_val", rs1Value, 32'h1234);

        // Asynchronous reset discards renames without waiting for a clock edge
        renameValid = 1; renameDest = 5'd5; renameRobId = 4'd4; step(); idle();
        rs1 = 5'd5; #1;
        chk("pre_rst_rdy", 32'(rs1Ready), 32'd0);
        #1 resetIn = 1; model_reset(); #1;
        chk("async_rst_rdy", 32'(rs1Ready), 32'd1);
        chk("async_rst_dep", 32'(rs1Dep), 32'd0);
        step(); resetIn = 0;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            readyIn        = ($urandom_range(0, 9) != 0);
            clear          = ($urandom_range(0, 19) == 0);
            regUpdateValid = $urandom_range(0, 1);
            regUpdateDest  = 5'($urandom_range(0, 7));
            regValue       = $urandom;
            regUpdateRobId = ($urandom_range(0, 1) != 0) ? m_tag[regUpdateDest] : 4'($urandom);
            renameValid    = $urandom_range(0, 1);
            renameDest     = 5'($urandom_range(0, 7));
            renameRobId    = 4'($urandom);
            rs1            = 5'($urandom_range(0, 7));
            rs2            = 5'($urandom_range(0, 7));
            rs1RobReady    = ($urandom_range(0, 3) == 0);
            rs2RobReady    = ($urandom_range(0, 3) == 0);
            rs1RobValue    = $urandom;
            rs2RobValue    = $urandom;
            #1;
            check_src("rnd_rs1", rs1, rs1RobReady, rs1RobValue, rs1Ready, rs1Value, rs1Tag, rs1Dep);
            check_src("rnd_rs2", rs2, rs2RobReady, rs2RobValue, rs2Ready, rs2Value, rs2Tag, rs2Dep);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
